// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Two-port req/gnt arbiter in front of the shared data RAM.
//            Port 0 is the CPU load/store unit and port 1 is the PIM engine.
//            Port 1 may lock the RAM for bursts. A per-port wait counter
//            forces a grant once it reaches MAX_WAIT, so neither port starves.
//            Build option ARB_ROUND_ROBIN_EN: when it is defined, ties are
//            resolved round-robin. When it is undefined, the CPU wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned AW       = 32
) (
  input  logic          CLK,
  input  logic          RST,
  // CPU port (port 0)
  input  logic          C_REQ,
  input  logic          C_WE,
  input  logic [AW-1:0] C_A,
  input  logic [31:0]   C_D,
  output logic          C_GNT,
  output logic          C_RVALID,
  output logic [31:0]   C_Q,
  // PIM port (port 1)
  input  logic          P_REQ,
  input  logic          P_WE,
  input  logic [AW-1:0] P_A,
  input  logic [31:0]   P_D,
  input  logic          P_LOCK,
  output logic          P_GNT,
  output logic          P_RVALID,
  output logic [31:0]   P_Q,
  // RAM side
  output logic [AW-1:0] RAM_A,
  output logic [31:0]   RAM_D,
  output logic          RAM_WE,
  input  logic [31:0]   RAM_Q
);

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  logic        last_q, last_d;
  logic        locked_q, locked_d;
  logic [7:0]  wait0_q, wait0_d;
  logic [7:0]  wait1_q, wait1_d;
  logic        c_rvalid_q, c_rvalid_d;
  logic        p_rvalid_q, p_rvalid_d;
  logic [31:0] c_q_q, c_q_d;
  logic [31:0] p_q_q, p_q_d;

  logic        force0, force1;
  logic        gnt0, gnt1;

  assign force0 = C_REQ && (wait0_q >= c_max_wait);
  assign force1 = P_REQ && (wait1_q >= c_max_wait);

  // Grant selection. The priority order is forced, then lock, then the normal policy. Reset suppresses all grants.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST) begin
      if (force0) begin
        gnt0 = 1'b1;            // CPU also wins when both counters are saturated
      end else if (force1) begin
        gnt1 = 1'b1;
      end else if (locked_q && P_REQ) begin
        gnt1 = 1'b1;
      end else if (C_REQ && P_REQ) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = C_REQ;
        gnt1 = P_REQ;
      end
    end
  end

  // Steer the granted port onto the RAM. When nothing is granted, drive all zeros.
  always_comb begin
    RAM_A  = '0;
    RAM_D  = '0;
    RAM_WE = 1'b0;
    if (gnt0) begin
      RAM_A  = C_A;
      RAM_D  = C_D;
      RAM_WE = C_WE;
    end else if (gnt1) begin
      RAM_A  = P_A;
      RAM_D  = P_D;
      RAM_WE = P_WE;
    end
  end

  // Next-state logic for the arbitration state and the read response stage.
  always_comb begin
    wait0_d = '0;
    if (C_REQ && !gnt0) wait0_d = (wait0_q == 8'hFF) ? wait0_q : wait0_q + 8'd1;
    wait1_d = '0;
    if (P_REQ && !gnt1) wait1_d = (wait1_q == 8'hFF) ? wait1_q : wait1_q + 8'd1;

    last_d = last_q;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;

    // A forced CPU grant breaks the lock, so the burst cannot reclaim the RAM at once.
    locked_d = locked_q;
    if (!P_REQ)                locked_d = 1'b0;
    else if (gnt0 && force0)   locked_d = 1'b0;
    else if (gnt1)             locked_d = P_LOCK;

    c_rvalid_d = gnt0 && !C_WE;
    p_rvalid_d = gnt1 && !P_WE;
    c_q_d      = c_rvalid_d ? RAM_Q : c_q_q;
    p_q_d      = p_rvalid_d ? RAM_Q : p_q_q;
  end

  // State registers. Reset drops any pending response and releases the lock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q     <= 1'b1;
      locked_q   <= 1'b0;
      wait0_q    <= '0;
      wait1_q    <= '0;
      c_rvalid_q <= 1'b0;
      p_rvalid_q <= 1'b0;
      c_q_q      <= '0;
      p_q_q      <= '0;
    end else begin
      last_q     <= last_d;
      locked_q   <= locked_d;
      wait0_q    <= wait0_d;
      wait1_q    <= wait1_d;
      c_rvalid_q <= c_rvalid_d;
      p_rvalid_q <= p_rvalid_d;
      c_q_q      <= c_q_d;
      p_q_q      <= p_q_d;
    end
  end

  assign C_GNT    = gnt0;
  assign P_GNT    = gnt1;
  assign C_RVALID = c_rvalid_q;
  assign P_RVALID = p_rvalid_q;
  assign C_Q      = c_q_q;
  assign P_Q      = p_q_q;

endmodule
`default_nettype wire
